// File: rtl/core_bus_port.sv
// core_bus_port: core-side request FIFO and request/grant initiator for the shared RAM bus
module core_bus_port #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_write,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_err,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data_out,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              bus_rvalid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = 1 + ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_inc, rd_inc, rd_one, count;
  logic [CW-1:0] cnt;
  logic full, empty, push, grant, avail, timeout;
  logic [EW-1:0] head, next_head, in_entry;
  logic req_d, rw_d, resp_valid_d, resp_write_d, resp_err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, resp_data_d;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign cpu_req_ready = !full;
  assign push = cpu_req_valid && !full;
  assign grant = state == REQ && bus_request && bus_grant;
  assign wr_inc = wr_ptr + PW'(push);
  assign rd_inc = rd_ptr + PW'(grant);
  assign rd_one = rd_ptr + PW'(1);
  assign count = wr_ptr - rd_ptr;
  assign avail = wr_inc != rd_inc;
  assign in_entry = {cpu_req_write, cpu_req_addr, cpu_req_wdata};
  assign head = mem[rd_ptr[AW-1:0]];
  assign next_head = count > PW'(1) ? mem[rd_one[AW-1:0]] : in_entry;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = empty ? IDLE : REQ;
      REQ:       if (grant) state_nxt = head[EW-1] ? (avail ? REQ : IDLE) : WAIT_DATA;
      WAIT_DATA: if (bus_rvalid || timeout) state_nxt = avail ? REQ : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_d = 1'b0;
    {rw_d, addr_d, wdata_d} = {bus_rw, bus_address, bus_data_out};
    resp_valid_d = 1'b0;
    resp_write_d = cpu_resp_write;
    resp_err_d = cpu_resp_err;
    resp_data_d = cpu_resp_data;
    if (state == REQ) begin
      if (!grant || (head[EW-1] && avail)) begin
        req_d = 1'b1;
        {rw_d, addr_d, wdata_d} = grant ? next_head : head;
      end
      if (grant && head[EW-1]) {resp_valid_d, resp_write_d, resp_err_d, resp_data_d} = {3'b110, {DATA_W{1'b0}}};
    end else if (state == WAIT_DATA && (bus_rvalid || timeout)) begin
      resp_valid_d = 1'b1;
      resp_write_d = 1'b0;
      resp_err_d = !bus_rvalid;
      resp_data_d = bus_rvalid ? bus_data_in : {DATA_W{1'b1}};
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bus_request <= 1'b0;
      bus_rw <= 1'b0;
      bus_address <= '0;
      bus_data_out <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_write <= 1'b0;
      cpu_resp_err <= 1'b0;
      cpu_resp_data <= '0;
    end else begin
      wr_ptr <= wr_inc;
      rd_ptr <= rd_inc;
      cnt <= state == WAIT_DATA ? cnt + 1'b1 : '0;
      bus_request <= req_d;
      bus_rw <= rw_d;
      bus_address <= addr_d;
      bus_data_out <= wdata_d;
      cpu_resp_valid <= resp_valid_d;
      cpu_resp_write <= resp_write_d;
      cpu_resp_err <= resp_err_d;
      cpu_resp_data <= resp_data_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
endmodule
